// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W       = 8;
    localparam int ARB_DATA_W       = 64;
    localparam int ARB_STARVE_LIMIT = 4;
    localparam int ARB_MAX_BURST    = 8;

    typedef enum logic [1:0] {
        ARB_NORM,
        ARB_HLOCK,
        ARB_YIELD
    } arb_state_t;

    typedef enum logic {
        RQ_CPU,
        RQ_HOST
    } rq_id_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive cycles the host waits without a grant; at the limit the
// host is forced to win the next arbitration.
module dmem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic host_req,
    input  logic host_gnt,
    output logic force_host
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!host_req || host_gnt) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_host = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a host port,
// with CPU priority, bounded host starvation and capped host lock bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int MAX_BURST    = ARB_MAX_BURST
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic              host_lock_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t         state;
    logic [BURST_W-1:0] burst_cnt;
    logic               rd_vld_p1;
    rq_id_t             rd_id_p1;

    logic cpu_gnt;
    logic host_gnt;
    logic force_host;
    logic at_cap;
    logic last_grant;

    dmem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .host_req  (host_req_i),
        .host_gnt  (host_gnt),
        .force_host(force_host)
    );

    assign at_cap     = (burst_cnt == BURST_W'(MAX_BURST));
    assign last_grant = host_gnt && (burst_cnt == BURST_W'(MAX_BURST - 1));

    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (rst_n_i) begin
            case (state)
                ARB_NORM: begin
                    if (host_req_i && (force_host || !cpu_req_i)) begin
                        host_gnt = 1'b1;
                    end else begin
                        cpu_gnt = cpu_req_i;
                    end
                end
                // A capped burst never takes another beat while the CPU waits.
                ARB_HLOCK: host_gnt = host_req_i && !(at_cap && cpu_req_i);
                ARB_YIELD: cpu_gnt  = cpu_req_i;
                default: begin
                    cpu_gnt  = 1'b0;
                    host_gnt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ARB_NORM;
            burst_cnt <= '0;
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= RQ_CPU;
        end else begin
            // p1: read issued last cycle, data arrives from memory now
            rd_vld_p1 <= (cpu_gnt && !cpu_we_i) || (host_gnt && !host_we_i);
            rd_id_p1  <= host_gnt ? RQ_HOST : RQ_CPU;
            case (state)
                ARB_NORM: begin
                    if (host_gnt && host_lock_i) begin
                        state     <= ARB_HLOCK;
                        burst_cnt <= BURST_W'(1);
                    end
                end
                ARB_HLOCK: begin
                    if (!host_req_i || !host_lock_i) begin
                        state     <= ARB_NORM;
                        burst_cnt <= '0;
                    end else begin
                        if (host_gnt && !at_cap) begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                        if (cpu_req_i && (at_cap || last_grant)) begin
                            state <= ARB_YIELD;
                        end
                    end
                end
                ARB_YIELD: begin
                    state     <= ARB_NORM;
                    burst_cnt <= '0;
                end
                default: begin
                    state     <= ARB_NORM;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    assign cpu_gnt_o   = cpu_gnt;
    assign host_gnt_o  = host_gnt;
    assign cpu_stall_o = rst_n_i && cpu_req_i && !cpu_gnt;

    assign mem_addr_o  = !rst_n_i ? '0 : (host_gnt ? host_addr_i  : cpu_addr_i);
    assign mem_wdata_o = !rst_n_i ? '0 : (host_gnt ? host_wdata_i : cpu_wdata_i);
    assign mem_we_o    = (cpu_gnt && cpu_we_i) || (host_gnt && host_we_i);

    // Gating with reset drops a read that was in flight when reset arrived.
    assign cpu_rvalid_o  = rst_n_i && rd_vld_p1 && (rd_id_p1 == RQ_CPU);
    assign host_rvalid_o = rst_n_i && rd_vld_p1 && (rd_id_p1 == RQ_HOST);
    assign cpu_rdata_o   = mem_rdata_i;
    assign host_rdata_o  = mem_rdata_i;

endmodule
